// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//
// Sits between a byte-level PS/2 receiver and a scan-code-to-ASCII decoder.
// Raw scan-code bytes pass through a prefix FSM that tracks E0 (extended) and
// F0 (break). Each complete make code is shown to the decoder for exactly one
// cycle as a 10-bit {ext, brk, code} word. Between make codes, key_code_o
// holds the neutral word 10'h300, which the decoder ignores. Break sequences
// are consumed without emitting anything. ASCII results from the decoder go
// into a show-ahead FIFO that the CPU drains with rd_en_i.
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_i              synchronous active-high reset
//   ps2_byte_valid_i   one-cycle strobe qualifying ps2_byte_i
//   ps2_byte_i         raw scan-code byte
//   key_code_o         decoder input word {ext, brk, code}, idles at 10'h300
//   ascii_valid_i      decoder result strobe
//   ascii_in_i         decoder ASCII result
//   rd_en_i            CPU pop strobe
//   rd_data_o          FIFO head (show-ahead)
//   empty_o / full_o   FIFO status
//   count_o            FIFO occupancy
//   overflow_o         sticky; a character was dropped while full
//   clr_ovf_i          clears overflow_o (a new overflow in the same cycle wins)

module ps2_key_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ps2_byte_valid_i,
    input  logic [7:0]                 ps2_byte_i,
    output logic [9:0]                 key_code_o,
    input  logic                       ascii_valid_i,
    input  logic [7:0]                 ascii_in_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [9:0]    KeyIdle  = 10'h300;
    localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   CntFull  = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [9:0]    key_code_q, key_code_d;

    // Bytes with no meaning as a key press (BAT result, ACK, echo, resend,
    // errors, Pause prefix) are dropped while idle.
    function automatic logic is_ignored(input logic [7:0] b);
        logic ign;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: ign = 1'b1;
            default:                                          ign = 1'b0;
        endcase
        return ign;
    endfunction

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        key_code_d = KeyIdle;

        if (ps2_byte_valid_i) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (ps2_byte_i == 8'hE0) begin
                        state_d = StExt;
                    end else if (ps2_byte_i == 8'hF0) begin
                        state_d = StBrk;
                    end else if (!is_ignored(ps2_byte_i)) begin
                        key_code_d = {2'b00, ps2_byte_i};
                    end
                end
                StExt: begin
                    if (ps2_byte_i == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (ps2_byte_i != 8'hE0) begin
                        key_code_d = {2'b10, ps2_byte_i};
                        state_d    = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    // Released key code: swallowed.
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // A stalled prefix (lost byte) must not poison the next key.
            if (tmo_q == TmoLimit) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            key_code_q <= KeyIdle;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            key_code_q <= key_code_d;
        end
    end

    assign key_code_o = key_code_q;

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full;
    logic          push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntFull);

    // When full, a simultaneous pop frees the slot the push needs.
    assign pop_ok  = rd_en_i & ~empty;
    assign push_ok = ascii_valid_i & (~full | rd_en_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (ascii_valid_i && full && !rd_en_i) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; contents are unreachable until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= ascii_in_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign empty_o    = empty;
    assign full_o     = full;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the PS/2 keyboard path between the byte-level PS/2 receiver and the scan-code-to-ASCII decoder, and buffers decoded characters for the CPU. It consumes raw scan-code bytes and runs a prefix FSM for E0 (extended) and F0 (break). It presents each complete make code to the decoder as a single-cycle 10-bit `{ext, brk, code}` word. Decoder results are pushed into a show-ahead FIFO that the CPU drains with a read strobe.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `TIMEOUT_CYC`, 100000, idle cycles allowed in a prefix state before the FSM returns to IDLE.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_byte_valid`  in  1  one-cycle strobe; `ps2_byte` is valid.
- `ps2_byte`  in  8  raw scan-code byte from the receiver.
- `key_code`  out  10  to decoder data input: [9]=ext, [8]=brk, [7:0]=code. Idle value 10'h300.
- `ascii_valid`  in  1  decoder ready pulse.
- `ascii_in`  in  8  decoder ASCII output.
- `rd_en`  in  1  CPU pop strobe.
- `rd_data`  out  8  FIFO head (show-ahead).
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a character was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- The decoder is level-sensitive. It re-fires on every cycle that a non-neutral word is held, and ignores any word with [9:8]=2'b11. `key_code` therefore idles at 10'h300 and carries a make word for exactly one cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK. The FSM only advances on `ps2_byte_valid`.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - AA, FA, EE, FE, 00, FF, E1 are ignored; stay in IDLE.
  - Any other byte: emit {2'b00, byte}; stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Any other byte: emit {2'b10, byte}; → IDLE.
- BRK, EXT_BRK: any byte → IDLE. Nothing is emitted; break sequences are consumed silently.
- Timeout:
  - In any non-IDLE state, a counter increments each cycle without `ps2_byte_valid`.
  - When it reaches TIMEOUT_CYC-1, the FSM → IDLE with no emit.
  - The counter clears on every byte and in IDLE.
- FIFO push: on `ascii_valid`, if not full, write `ascii_in` at the tail.
- FIFO pop: on `rd_en & !empty`, advance the head.
- `rd_en` while empty is ignored; no state change.
- Push while full without a simultaneous pop: the character is dropped and `overflow` is set.
- Push and pop in the same cycle:
  - When full: both happen; `count` is unchanged; no overflow.
  - When empty: the pop is ignored; the push happens.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is a separate counter updated by +1, -1 or 0.
- `overflow`: set has priority over `clr_ovf` in the same cycle. It clears only on `clr_ovf` or `rst`.

## Timing
- Reset values:
  - FSM IDLE, timeout counter 0, FIFO pointers and `count` 0.
  - `key_code`=10'h300, `empty`=1, `full`=0, `overflow`=0.
  - `rd_data` reflects the entry at pointer 0 and is don't-care while empty.
- Reset asserted mid-sequence (e.g. in EXT after E0): the prefix is discarded, the FIFO contents are lost, and all outputs take reset values on the next edge.
- Latency:
  - Byte strobe at cycle N → `key_code` holds the make word during N+1 and returns to 10'h300 at N+2.
  - The decoder registers, so `ascii_valid` is seen at N+2.
  - `empty` falls and `rd_data` is valid at N+3.
- `rd_data`, `empty`, `full` and `count` reflect registered state and have no combinational path from `rd_en`. The pop takes effect at the next edge.
- Back-to-back byte strobes on consecutive cycles are supported. Each make word occupies one cycle of `key_code`.

## Test plan
- Send 1C, then 32 (two strobes, 10 cycles apart) → `key_code` pulses 10'h01C and 10'h032 for one cycle each. FIFO holds 8'h41, 8'h42; `count`=2. Two `rd_en` pulses return A, then B; `empty`=1.
- Send E0 74, then E0 F0 74 → one emit of 10'h274 only. FIFO gets 8'h1C; FSM ends in IDLE.
- Send F0 1C, then AA, then FA → no `key_code` pulse other than 10'h300; FIFO stays empty.
- Fill with DEPTH+1 make codes, no reads → `full`=1, `count`=DEPTH, `overflow`=1, and the first DEPTH characters read back in order. Then hold `ascii_valid` with `rd_en` while full → `count` is unchanged and `overflow` stays set. Pulse `clr_ovf` → `overflow`=0.
- Send E0, wait TIMEOUT_CYC cycles, send 1C → emits 10'h01C (not 10'h21C). Repeat with `rst` asserted after E0 → same result; all outputs at reset values during reset.
